load_extend_unit: RTL and testbench

//  Parametrised load-data aligner/extender with registered output and a 2-entry skid buffer.

---
 rtl/load_extend_unit.sv | 140 ++++++++++++++
 tb/tb_load_extend_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_extend_unit.sv
// Load-data aligner/extender: picks a byte/half/word/dword field out of a
// memory read word, extends it, and hands it on through a registered 2-entry skid buffer.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_valid/in_ready        input handshake (in_ready is a pure register output)
//   in_data, in_off,         raw read word, byte offset,
//   in_size, in_signed       access size (00 b, 01 h, 10 w, 11 d), sign-extend flag
//   in_tag                   sideband tag, passed through unchanged
//   out_valid/out_ready      output handshake
//   out_data, out_tag        extended result and its tag
//   out_misalign             beat was misaligned or used an illegal size
//   misalign_cnt             saturating count of delivered misaligned beats

module load_extend_unit #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 2,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_misalign,
    output logic [CNT_W-1:0]  misalign_cnt
);

    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_res;
    logic [6:0]        w_nbits;
    logic [OFF_W-1:0]  w_lowmask;
    logic              w_msb;
    logic              w_mis;

    // Field extraction: shift the field down to bit 0, keep the low nbits,
    // and fill the rest with the sign bit or zeros.
    always_comb begin
        w_shift   = in_data >> {in_off, 3'b000};
        w_nbits   = 7'd8 << in_size;
        // A full-width field shifts the ones completely out, giving an all-ones mask.
        w_mask    = ~({DATA_W{1'b1}} << w_nbits);
        w_lowmask = OFF_W'((1 << in_size) - 1);
        case (in_size)
            2'b00:   w_msb = w_shift[7];
            2'b01:   w_msb = w_shift[15];
            2'b10:   w_msb = w_shift[31];
            default: w_msb = w_shift[DATA_W-1];
        endcase
        w_mis = ((in_off & w_lowmask) != '0) ||
                ((DATA_W == 32) && (in_size == 2'b11));
        w_res = (w_shift & w_mask) |
                ({DATA_W{in_signed & w_msb}} & ~w_mask);
        if (w_mis) begin
            w_res = '0;
        end
    end

    logic              r_rdy;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [TAG_W-1:0]  r_m_tag;
    logic              r_m_mis;
    logic              r_s_valid;
    logic [DATA_W-1:0] r_s_data;
    logic [TAG_W-1:0]  r_s_tag;
    logic              r_s_mis;
    logic [CNT_W-1:0]  r_cnt;

    logic w_acc;
    logic w_pop;
    logic w_load_m;
    logic w_s_nxt;

    always_comb begin
        w_acc    = in_valid & r_rdy;
        w_pop    = r_m_valid & out_ready;
        w_load_m = ~r_m_valid | w_pop;
        // S drains whenever M reloads; it only fills when M is stuck.
        w_s_nxt  = w_load_m ? 1'b0 : (r_s_valid | w_acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy     <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_tag   <= '0;
            r_m_mis   <= 1'b0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_tag   <= '0;
            r_s_mis   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_rdy     <= ~w_s_nxt;
            r_s_valid <= w_s_nxt;
            if (w_load_m) begin
                if (r_s_valid) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= r_s_data;
                    r_m_tag   <= r_s_tag;
                    r_m_mis   <= r_s_mis;
                end else if (w_acc) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= w_res;
                    r_m_tag   <= in_tag;
                    r_m_mis   <= w_mis;
                end else begin
                    r_m_valid <= 1'b0;
                end
            end else if (w_acc) begin
                r_s_data <= w_res;
                r_s_tag  <= in_tag;
                r_s_mis  <= w_mis;
            end
            if (w_pop && r_m_mis && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready     = r_rdy;
    assign out_valid    = r_m_valid;
    assign out_data     = r_m_data;
    assign out_tag      = r_m_tag;
    assign out_misalign = r_m_mis;
    assign misalign_cnt = r_cnt;

endmodule

// File: tb/tb_load_extend_unit.sv
// Directed-vector bench for load_extend_unit: a 32-bit instance with a
// 2-bit counter for saturation, and a 64-bit instance for dword access.

module tb_load_extend_unit;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_off;
    logic [1:0]  in_size;
    logic        in_signed;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_misalign;
    logic [1:0]  misalign_cnt;

    logic        w64_in_valid;
    logic        w64_in_ready;
    logic [63:0] w64_in_data;
    logic [2:0]  w64_in_off;
    logic [1:0]  w64_in_size;
    logic        w64_in_signed;
    logic [4:0]  w64_in_tag;
    logic        w64_out_valid;
    logic        w64_out_ready;
    logic [63:0] w64_out_data;
    logic [4:0]  w64_out_tag;
    logic        w64_out_misalign;
    logic [15:0] w64_misalign_cnt;

    int n_vec;
    int n_err;
    int exp_t;
    logic take;

    load_extend_unit #(
        .DATA_W(32), .OFF_W(2), .TAG_W(5), .CNT_W(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_off(in_off),
        .in_size(in_size), .in_signed(in_signed),
        .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag),
        .out_misalign(out_misalign),
        .misalign_cnt(misalign_cnt)
    );

    load_extend_unit #(
        .DATA_W(64), .OFF_W(3), .TAG_W(5), .CNT_W(16)
    ) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w64_in_valid), .in_ready(w64_in_ready),
        .in_data(w64_in_data), .in_off(w64_in_off),
        .in_size(w64_in_size), .in_signed(w64_in_signed),
        .in_tag(w64_in_tag),
        .out_valid(w64_out_valid), .out_ready(w64_out_ready),
        .out_data(w64_out_data), .out_tag(w64_out_tag),
        .out_misalign(w64_out_misalign),
        .misalign_cnt(w64_misalign_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic [1:0] off,
                         input logic [1:0] sz, input logic sg,
                         input logic [4:0] tg);
        in_data   = d;
        in_off    = off;
        in_size   = sz;
        in_signed = sg;
        in_tag    = tg;
        in_valid  = 1'b1;
    endtask

    task automatic drive64(input logic [63:0] d, input logic [2:0] off,
                           input logic [1:0] sz, input logic sg);
        w64_in_data   = d;
        w64_in_off    = off;
        w64_in_size   = sz;
        w64_in_signed = sg;
        w64_in_tag    = 5'd4;
        w64_in_valid  = 1'b1;
        @(posedge clk); #1;
        w64_in_valid  = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0; in_off = '0; in_size = '0;
        in_signed = 1'b0; in_tag = '0;
        out_ready = 1'b1;
        w64_in_valid = 1'b0;
        w64_in_data = '0; w64_in_off = '0; w64_in_size = '0;
        w64_in_signed = 1'b0; w64_in_tag = '0;
        w64_out_ready = 1'b1;

        // reset state
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_cnt", 64'(misalign_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // signed byte, latency 1
        @(negedge clk);
        drive(32'h1234_F678, 2'd1, 2'b00, 1'b1, 5'd3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'hFFFF_FFF6);
        chk("t1_tag", 64'(out_tag), 64'd3);

        // half unsigned then signed, back to back
        @(negedge clk);
        drive(32'h8001_0000, 2'd2, 2'b01, 1'b0, 5'd5);
        @(posedge clk); #1;
        chk("t2_unsigned", 64'(out_data), 64'h0000_8001);
        chk("t2_mis", 64'(out_misalign), 64'd0);
        drive(32'h8001_0000, 2'd2, 2'b01, 1'b1, 5'd6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t2_signed", 64'(out_data), 64'hFFFF_8001);
        chk("t2_tag", 64'(out_tag), 64'd6);

        // misaligned half, illegal size
        @(negedge clk);
        drive(32'hABCD_EF01, 2'd1, 2'b01, 1'b1, 5'd7);
        @(posedge clk); #1;
        chk("t3_mis", 64'(out_misalign), 64'd1);
        chk("t3_data", 64'(out_data), 64'd0);
        chk("t3_cnt0", 64'(misalign_cnt), 64'd0);
        drive(32'h1234_5678, 2'd0, 2'b11, 1'b0, 5'd8);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t3_ill_mis", 64'(out_misalign), 64'd1);
        chk("t3_ill_data", 64'(out_data), 64'd0);
        chk("t3_cnt1", 64'(misalign_cnt), 64'd1);
        @(posedge clk); #1;
        chk("t3_cnt2", 64'(misalign_cnt), 64'd2);

        // backpressure: fill M and S, third beat waits
        @(negedge clk);
        out_ready = 1'b0;
        drive(32'h0000_0011, 2'd0, 2'b10, 1'b0, 5'd1);
        @(posedge clk); #1;
        chk("t4_rdy1", 64'(in_ready), 64'd1);
        drive(32'h0000_0022, 2'd0, 2'b10, 1'b0, 5'd2);
        @(posedge clk); #1;
        chk("t4_rdy0", 64'(in_ready), 64'd0);
        chk("t4_head", 64'(out_tag), 64'd1);
        drive(32'h0000_0033, 2'd0, 2'b10, 1'b0, 5'd3);
        @(posedge clk); #1;
        chk("t4_hold_tag", 64'(out_tag), 64'd1);
        chk("t4_hold_data", 64'(out_data), 64'h11);
        exp_t = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) out_ready = 1'b1;
            if (out_valid && out_ready) begin
                chk("t4_order", 64'(out_tag), 64'(exp_t));
                exp_t++;
            end
            take = in_valid && in_ready;
            @(posedge clk); #1;
            if (take) in_valid = 1'b0;
        end
        chk("t4_count", 64'(exp_t), 64'd4);

        // async reset with M and S full
        @(negedge clk);
        out_ready = 1'b0;
        drive(32'h0000_FFFF, 2'd1, 2'b01, 1'b0, 5'd9);
        @(posedge clk); #1;
        drive(32'h0000_1234, 2'd0, 2'b01, 1'b0, 5'd10);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t5_full_rdy", 64'(in_ready), 64'd0);
        chk("t5_full_mis", 64'(out_misalign), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_tag", 64'(out_tag), 64'd0);
        chk("t5_mis", 64'(out_misalign), 64'd0);
        chk("t5_rdy", 64'(in_ready), 64'd0);
        chk("t5_cnt", 64'(misalign_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t5_rdy_after", 64'(in_ready), 64'd1);
        chk("t5_no_stale0", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("t5_no_stale1", 64'(out_valid), 64'd0);

        // saturation: five misaligned beats with a 2-bit counter
        @(negedge clk);
        drive(32'h5555_AAAA, 2'd3, 2'b01, 1'b0, 5'd11);
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_sat", 64'(misalign_cnt), 64'd3);
        chk("t6_drain", 64'(out_valid), 64'd0);

        // 64-bit instance
        @(negedge clk);
        drive64(64'h8123_4567_89AB_CDEF, 3'd0, 2'b11, 1'b1);
        chk("w64_dword", w64_out_data, 64'h8123_4567_89AB_CDEF);
        chk("w64_dword_mis", 64'(w64_out_misalign), 64'd0);
        drive64(64'h8000_0000_0000_0000, 3'd7, 2'b00, 1'b1);
        chk("w64_byte7", w64_out_data, 64'hFFFF_FFFF_FFFF_FF80);
        drive64(64'hF000_0001_0000_0000, 3'd4, 2'b10, 1'b0);
        chk("w64_word_u", w64_out_data, 64'h0000_0000_F000_0001);
        drive64(64'hF000_0001_0000_0000, 3'd4, 2'b10, 1'b1);
        chk("w64_word_s", w64_out_data, 64'hFFFF_FFFF_F000_0001);
        drive64(64'h1111_2222_3333_4444, 3'd4, 2'b11, 1'b0);
        chk("w64_dw_mis", 64'(w64_out_misalign), 64'd1);
        chk("w64_dw_data", w64_out_data, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
